phyretrain_sb_arbiter: RTL and testbench

//  Shares the single sideband (SB) transmit port between the TX and RX PHYRETRAIN sub-FSMs.

---
 rtl/phyretrain_sb_arbiter_pkg.sv | 35 +++
 rtl/phyretrain_sb_arbiter_if.sv | 33 +++
 rtl/phyretrain_sb_arbiter_sb_busy_edge_detector.sv | 23 ++
 rtl/phyretrain_sb_arbiter.sv | 142 ++++++++++++++
 tb/tb_phyretrain_sb_arbiter.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/phyretrain_sb_arbiter_pkg.sv
// Shared PHYRETRAIN sideband definitions: message codes, retrain encodings,
// arbiter states and grant ids, plus the round-robin tie-break helper.
package ltsm_sb_pkg;

    localparam logic [3:0] MSG_START_REQ  = 4'd1;
    localparam logic [3:0] MSG_START_RESP = 4'd2;

    localparam logic [2:0] ENC_TXSELFCAL = 3'b001;
    localparam logic [2:0] ENC_SPEEDIDLE = 3'b010;
    localparam logic [2:0] ENC_REPAIR    = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_COOLDOWN  = 2'd3
    } arb_state_e;

    typedef enum logic {
        GRANT_TX = 1'b0,
        GRANT_RX = 1'b1
    } grant_e;

    // On a tie the requester that was not granted last wins.
    function automatic grant_e pick_winner(input logic tx_req, input logic rx_req,
                                           input grant_e last);
        if (tx_req && rx_req) begin
            return (last == GRANT_TX) ? GRANT_RX : GRANT_TX;
        end else if (tx_req) begin
            return GRANT_TX;
        end
        return GRANT_RX;
    endfunction

endpackage

// File: rtl/phyretrain_sb_arbiter_if.sv
// Request/SB-encoder bundle between the PHYRETRAIN TX/RX FSMs and the arbiter.
interface phyretrain_sb_arbiter_if #(
    parameter int unsigned SB_MSG_WIDTH = 4
);
    logic                    i_enable;
    logic                    i_tx_valid;
    logic [SB_MSG_WIDTH-1:0] i_tx_msg;
    logic [2:0]              i_tx_encoding;
    logic                    i_rx_valid;
    logic [SB_MSG_WIDTH-1:0] i_rx_msg;
    logic                    i_sb_busy;
    logic [SB_MSG_WIDTH-1:0] o_sb_msg;
    logic [2:0]              o_sb_encoding;
    logic                    o_sb_valid;
    logic                    o_release_tx;
    logic                    o_release_rx;
    logic                    o_timeout;

    modport slave (
        input  i_enable, i_tx_valid, i_tx_msg, i_tx_encoding,
        input  i_rx_valid, i_rx_msg, i_sb_busy,
        output o_sb_msg, o_sb_encoding, o_sb_valid,
        output o_release_tx, o_release_rx, o_timeout
    );

    modport master (
        output i_enable, i_tx_valid, i_tx_msg, i_tx_encoding,
        output i_rx_valid, i_rx_msg, i_sb_busy,
        input  o_sb_msg, o_sb_encoding, o_sb_valid,
        input  o_release_tx, o_release_rx, o_timeout
    );

endinterface

// File: rtl/phyretrain_sb_arbiter_sb_busy_edge_detector.sv
// Registers SB busy and flags its rising and falling edges.
module sb_busy_edge_detector (
    input  logic clk,
    input  logic rst_n,
    input  logic busy,
    output logic busy_fall,
    output logic busy_rise
);

    logic busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= busy;
        end
    end

    assign busy_fall = busy_q & ~busy;
    assign busy_rise = ~busy_q & busy;

endmodule

// File: rtl/phyretrain_sb_arbiter.sv
// Arbitrates the single SB transmit port between the PHYRETRAIN TX and RX FSMs,
// with round-robin ties, release pulses on SB completion and a transfer timeout.
module phyretrain_sb_arbiter #(
    parameter int unsigned SB_MSG_WIDTH   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    phyretrain_sb_arbiter_if.slave  sb
);
    import ltsm_sb_pkg::*;

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    arb_state_e              state_q, state_d;
    grant_e                  last_grant_q, last_grant_d;
    grant_e                  winner;
    logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
    logic [SB_MSG_WIDTH-1:0] msg_q, msg_d;
    logic [2:0]              enc_q, enc_d;
    logic                    valid_q, valid_d;
    logic                    rel_tx_q, rel_tx_d;
    logic                    rel_rx_q, rel_rx_d;
    logic                    timeout_q, timeout_d;
    logic                    busy_fall, busy_rise;
    logic                    any_req, timeout_hit;

    sb_busy_edge_detector u_busy_edge (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .busy      (sb.i_sb_busy),
        .busy_fall (busy_fall),
        .busy_rise (busy_rise)
    );

    assign any_req     = sb.i_tx_valid | sb.i_rx_valid;
    assign winner      = pick_winner(sb.i_tx_valid, sb.i_rx_valid, last_grant_q);
    assign cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    assign timeout_hit = TIMEOUT_EN && (cnt_inc == CNT_MAX);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        msg_d        = msg_q;
        enc_d        = enc_q;
        valid_d      = valid_q;
        rel_tx_d     = 1'b0;
        rel_rx_d     = 1'b0;
        timeout_d    = 1'b0;

        if (!sb.i_enable) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!sb.i_sb_busy && any_req) begin
                        state_d      = ST_ISSUE;
                        last_grant_d = winner;
                        cnt_d        = '0;
                        valid_d      = 1'b1;
                        if (winner == GRANT_TX) begin
                            msg_d = sb.i_tx_msg;
                            enc_d = sb.i_tx_encoding;
                        end else begin
                            msg_d = sb.i_rx_msg;
                            enc_d = '0;
                        end
                    end
                end
                ST_ISSUE: begin
                    cnt_d = cnt_inc;
                    // busy was low on the grant edge and on every ISSUE edge since,
                    // so a rise here is exactly "busy is now high".
                    if (timeout_hit) begin
                        state_d   = ST_COOLDOWN;
                        valid_d   = 1'b0;
                        timeout_d = 1'b1;
                        rel_tx_d  = (last_grant_q == GRANT_TX);
                        rel_rx_d  = (last_grant_q == GRANT_RX);
                    end else if (busy_rise) begin
                        state_d = ST_WAIT_BUSY;
                        valid_d = 1'b0;
                    end
                end
                ST_WAIT_BUSY: begin
                    cnt_d = cnt_inc;
                    if (busy_fall || timeout_hit) begin
                        state_d   = ST_COOLDOWN;
                        valid_d   = 1'b0;
                        timeout_d = ~busy_fall;
                        rel_tx_d  = (last_grant_q == GRANT_TX);
                        rel_rx_d  = (last_grant_q == GRANT_RX);
                    end
                end
                ST_COOLDOWN: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GRANT_RX;
            cnt_q        <= '0;
            msg_q        <= '0;
            enc_q        <= '0;
            valid_q      <= 1'b0;
            rel_tx_q     <= 1'b0;
            rel_rx_q     <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            msg_q        <= msg_d;
            enc_q        <= enc_d;
            valid_q      <= valid_d;
            rel_tx_q     <= rel_tx_d;
            rel_rx_q     <= rel_rx_d;
            timeout_q    <= timeout_d;
        end
    end

    assign sb.o_sb_msg      = msg_q;
    assign sb.o_sb_encoding = enc_q;
    assign sb.o_sb_valid    = valid_q;
    assign sb.o_release_tx  = rel_tx_q;
    assign sb.o_release_rx  = rel_rx_q;
    assign sb.o_timeout     = timeout_q;

endmodule

// File: tb/tb_phyretrain_sb_arbiter.sv
// Self-checking bench for phyretrain_sb_arbiter: transaction-level reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_phyretrain_sb_arbiter;
    import ltsm_sb_pkg::*;

    localparam int unsigned W = 4;
    localparam int T = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    phyretrain_sb_arbiter_if #(.SB_MSG_WIDTH(W)) sb ();

    phyretrain_sb_arbiter #(.SB_MSG_WIDTH(W), .TIMEOUT_CYCLES(T)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .sb      (sb)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner of the SB (-1 none, 0 TX, 1 RX), whether the SB
    // accepted the message, cycles since grant, and a one-cycle cooldown flag.
    int         m_owner, m_age, m_last, m_w;
    bit         m_acc, m_cool, m_prev_busy, m_fall, m_hit;
    logic [W-1:0] e_msg;
    logic [2:0] e_enc;
    bit         e_valid, e_rtx, e_rrx, e_to;

    task m_end(input bit to);
        e_valid = 1'b0;
        e_to    = to;
        e_rtx   = (m_owner == 0);
        e_rrx   = (m_owner == 1);
        m_owner = -1;
        m_cool  = 1'b1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1; m_acc = 0; m_cool = 0; m_age = 0; m_last = 1; m_prev_busy = 0;
            e_msg = '0; e_enc = '0; e_valid = 0; e_rtx = 0; e_rrx = 0; e_to = 0;
        end else begin
            m_fall = m_prev_busy && !sb.i_sb_busy;
            e_rtx = 0; e_rrx = 0; e_to = 0;
            if (!sb.i_enable) begin
                m_owner = -1; m_cool = 0; e_valid = 0;
            end else if (m_cool) begin
                m_cool = 0;
            end else if (m_owner < 0) begin
                if (!sb.i_sb_busy && (sb.i_tx_valid || sb.i_rx_valid)) begin
                    if (sb.i_tx_valid && sb.i_rx_valid) m_w = 1 - m_last;
                    else m_w = sb.i_tx_valid ? 0 : 1;
                    m_owner = m_w; m_last = m_w; m_acc = 0; m_age = 0; e_valid = 1;
                    e_msg = (m_w == 1) ? sb.i_rx_msg : sb.i_tx_msg;
                    e_enc = (m_w == 1) ? 3'b000 : sb.i_tx_encoding;
                end
            end else begin
                m_age = (m_age < T) ? m_age + 1 : T;
                m_hit = (T != 0) && (m_age == T);
                if (!m_acc) begin
                    if (m_hit) m_end(1);
                    else if (sb.i_sb_busy) begin m_acc = 1; e_valid = 0; end
                end else if (m_fall) m_end(0);
                else if (m_hit) m_end(1);
            end
            m_prev_busy = sb.i_sb_busy;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_valid", sb.o_sb_valid, e_valid);
            chk("model_msg", sb.o_sb_msg, e_msg);
            chk("model_enc", sb.o_sb_encoding, e_enc);
            chk("model_rel_tx", sb.o_release_tx, e_rtx);
            chk("model_rel_rx", sb.o_release_rx, e_rrx);
            chk("model_timeout", sb.o_timeout, e_to);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        sb.i_enable = 1'b1; sb.i_tx_valid = 1'b0; sb.i_rx_valid = 1'b0; sb.i_sb_busy = 1'b0;
        sb.i_tx_msg = '0; sb.i_rx_msg = '0; sb.i_tx_encoding = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Wait for a grant, emulate the SB serialising it, drop the released valid.
    task automatic serve(input string name, output int msg_seen);
        bit got;
        msg_seen = -1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (sb.o_sb_valid) got = 1; else tick();
        end
        chk({name, "_grant_seen"}, got, 1);
        if (!got) return;
        msg_seen = int'(sb.o_sb_msg);
        sb.i_sb_busy = 1'b1;
        tick(); tick();
        sb.i_sb_busy = 1'b0;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            if (sb.o_release_tx) begin sb.i_tx_valid = 1'b0; got = 1; end
            if (sb.o_release_rx) begin sb.i_rx_valid = 1'b0; got = 1; end
        end
        chk({name, "_release_seen"}, got, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int m;
        int n_tx, n_rx, n_to;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("reset_valid", sb.o_sb_valid, 0);
        chk("reset_msg", sb.o_sb_msg, 0);
        chk("reset_enc", sb.o_sb_encoding, 0);
        chk("reset_pulses", {sb.o_release_tx, sb.o_release_rx, sb.o_timeout}, 0);

        // 1: TX only; busy falls on the same edge the timeout would hit
        do_reset();
        sb.i_tx_valid = 1'b1; sb.i_tx_msg = MSG_START_REQ; sb.i_tx_encoding = ENC_REPAIR;
        tick();
        chk("t1_valid", sb.o_sb_valid, 1);
        chk("t1_msg", sb.o_sb_msg, 1);
        chk("t1_enc", sb.o_sb_encoding, 3'b100);
        tick(); tick();
        sb.i_sb_busy = 1'b1;
        repeat (5) tick();
        sb.i_sb_busy = 1'b0;
        n_tx = 0; n_rx = 0; n_to = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_tx += int'(sb.o_release_tx); n_rx += int'(sb.o_release_rx); n_to += int'(sb.o_timeout);
            if (sb.o_release_tx) sb.i_tx_valid = 1'b0;
        end
        chk("t1_rel_tx_count", n_tx, 1);
        chk("t1_rel_rx_count", n_rx, 0);
        chk("t1_timeout_count", n_to, 0);

        // 2: ties alternate starting with TX
        do_reset();
        sb.i_tx_valid = 1'b1; sb.i_tx_msg = MSG_START_REQ; sb.i_tx_encoding = ENC_SPEEDIDLE;
        sb.i_rx_valid = 1'b1; sb.i_rx_msg = MSG_START_RESP;
        serve("t2_a", m); chk("t2_first_tx", m, 1);
        serve("t2_b", m); chk("t2_second_rx", m, 2);
        sb.i_tx_valid = 1'b1; sb.i_rx_valid = 1'b1;
        serve("t2_c", m); chk("t2_third_tx", m, 1);
        sb.i_tx_valid = 1'b1;
        serve("t2_d", m); chk("t2_fourth_rx", m, 2);

        // 3: enable drop while RX is in flight
        do_reset();
        sb.i_rx_valid = 1'b1; sb.i_rx_msg = MSG_START_RESP;
        tick();
        chk("t3_valid", sb.o_sb_valid, 1);
        chk("t3_enc_rx", sb.o_sb_encoding, 0);
        sb.i_sb_busy = 1'b1;
        tick();
        chk("t3_valid_off", sb.o_sb_valid, 0);
        sb.i_enable = 1'b0;
        tick();
        chk("t3_abort_valid", sb.o_sb_valid, 0);
        chk("t3_abort_pulses", {sb.o_release_tx, sb.o_release_rx, sb.o_timeout}, 0);
        sb.i_sb_busy = 1'b0;
        tick();
        chk("t3_no_release", {sb.o_release_tx, sb.o_release_rx, sb.o_timeout}, 0);
        sb.i_enable = 1'b1;
        serve("t3_regrant", m); chk("t3_regrant_msg", m, 2);

        // 4: timeout when busy never rises
        do_reset();
        sb.i_tx_valid = 1'b1; sb.i_tx_msg = MSG_START_REQ; sb.i_tx_encoding = ENC_TXSELFCAL;
        tick();
        chk("t4_valid", sb.o_sb_valid, 1);
        for (int i = 1; i <= T; i++) begin
            tick();
            chk("t4_timeout_timing", sb.o_timeout, (i == T));
        end
        chk("t4_rel_tx", sb.o_release_tx, 1);
        chk("t4_valid_off", sb.o_sb_valid, 0);
        sb.i_tx_valid = 1'b0;
        tick();
        chk("t4_valid_after", sb.o_sb_valid, 0);

        // 5: busy already high when TX requests
        do_reset();
        sb.i_sb_busy = 1'b1;
        sb.i_tx_valid = 1'b1; sb.i_tx_msg = MSG_START_REQ; sb.i_tx_encoding = ENC_REPAIR;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_blocked", sb.o_sb_valid, 0);
        end
        sb.i_sb_busy = 1'b0;
        tick();
        chk("t5_grant", sb.o_sb_valid, 1);
        serve("t5", m);

        // 6: asynchronous reset mid-ISSUE
        do_reset();
        sb.i_tx_valid = 1'b1; sb.i_tx_msg = MSG_START_REQ; sb.i_tx_encoding = ENC_REPAIR;
        tick();
        chk("t6_valid", sb.o_sb_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_valid", sb.o_sb_valid, 0);
        chk("t6_async_msg", sb.o_sb_msg, 0);
        chk("t6_async_enc", sb.o_sb_encoding, 0);
        sb.i_rx_valid = 1'b1; sb.i_rx_msg = MSG_START_RESP;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("t6_tie_tx", sb.o_sb_msg, 1);
        chk("t6_tie_valid", sb.o_sb_valid, 1);

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            tick();
            if (sb.o_release_tx) begin
                if ($urandom_range(0, 3) != 0) sb.i_tx_valid = 1'b0;
            end else if (!sb.i_tx_valid && $urandom_range(0, 3) == 0) begin
                sb.i_tx_valid = 1'b1;
                sb.i_tx_msg = W'($urandom);
                case ($urandom_range(0, 2))
                    0: sb.i_tx_encoding = ENC_TXSELFCAL;
                    1: sb.i_tx_encoding = ENC_SPEEDIDLE;
                    default: sb.i_tx_encoding = ENC_REPAIR;
                endcase
            end
            if (sb.o_release_rx) begin
                if ($urandom_range(0, 3) != 0) sb.i_rx_valid = 1'b0;
            end else if (!sb.i_rx_valid && $urandom_range(0, 3) == 0) begin
                sb.i_rx_valid = 1'b1;
                sb.i_rx_msg = W'($urandom);
            end
            if (sb.i_sb_busy) sb.i_sb_busy = ($urandom_range(0, 2) != 0);
            else if (sb.o_sb_valid) sb.i_sb_busy = ($urandom_range(0, 2) == 0);
            else sb.i_sb_busy = ($urandom_range(0, 19) == 0);
            sb.i_enable = ($urandom_range(0, 49) != 0);
        end
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
